// File: rtl/int_divider_accel_adapter.sv
// Accelerator-bus adapter for a 16-cycle restoring integer divider.
// Define INT_DIVIDER_SIGNED_EN for two's-complement operands; the default build divides unsigned.
module int_divider_accel_adapter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  accel_can_read,
    output logic                  accel_can_write,
    input  logic                  accel_read_enable,
    input  logic                  accel_write_enable,
    output logic [DATA_WIDTH-1:0] accel_read_data,
    input  logic [DATA_WIDTH-1:0] accel_write_data
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [2:0] {
        S_DIVIDEND,
        S_DIVISOR,
        S_BUSY,
        S_QUOTIENT,
        S_REMAINDER
    } state_t;

    state_t         state;
    logic [W-1:0]   dividend_reg;
    logic [W-1:0]   divisor_reg;
    logic [W-1:0]   quotient_reg;
    logic [W-1:0]   remainder_reg;
    logic [W:0]     part_rem;
    logic [W-1:0]   quo_shift;
    logic [4:0]     step_count;

    logic [W-1:0]   dividend_mag;
    logic [W-1:0]   divisor_mag;
    logic [W:0]     shifted;
    logic [W:0]     trial;
    logic           fits;
    logic [W:0]     next_rem;
    logic [W-1:0]   next_quo;
    logic [W-1:0]   final_quo;
    logic [W-1:0]   final_rem;
    logic           rem_msb_unused;

    // The top partial-remainder bit is always clear after a restoring step.
    assign rem_msb_unused = part_rem[W];

    assign shifted  = {part_rem[W-1:0], quo_shift[W-1]};
    assign trial    = shifted - {1'b0, divisor_mag};
    assign fits     = shifted >= {1'b0, divisor_mag};
    assign next_rem = fits ? trial : shifted;
    assign next_quo = {quo_shift[W-2:0], fits};

`ifdef INT_DIVIDER_SIGNED_EN
    logic neg_quotient;
    logic neg_remainder;

    // A zero divisor keeps the all-ones quotient unnegated so it still reads 16'hFFFF.
    always_comb begin
        dividend_mag  = dividend_reg[W-1] ? -dividend_reg : dividend_reg;
        divisor_mag   = divisor_reg[W-1]  ? -divisor_reg  : divisor_reg;
        neg_remainder = dividend_reg[W-1];
        neg_quotient  = (dividend_reg[W-1] ^ divisor_reg[W-1]) && (divisor_reg != '0);
        final_quo     = neg_quotient  ? -next_quo           : next_quo;
        final_rem     = neg_remainder ? -next_rem[W-1:0]    : next_rem[W-1:0];
    end
`else
    assign dividend_mag = dividend_reg;
    assign divisor_mag  = divisor_reg;
    assign final_quo    = next_quo;
    assign final_rem    = next_rem[W-1:0];
`endif

    always_comb begin
        accel_read_data = '0;
        if (state == S_QUOTIENT)
            accel_read_data = quotient_reg;
        else if (state == S_REMAINDER)
            accel_read_data = remainder_reg;
    end

    // Reset has priority over every bus enable, and aborts a division in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_DIVIDEND;
            step_count      <= '0;
            dividend_reg    <= '0;
            divisor_reg     <= '0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            part_rem        <= '0;
            quo_shift       <= '0;
            accel_can_read  <= 1'b0;
            accel_can_write <= 1'b1;
        end else begin
            case (state)
                S_DIVIDEND: begin
                    if (accel_write_enable) begin
                        dividend_reg <= accel_write_data;
                        state        <= S_DIVISOR;
                    end
                end
                S_DIVISOR: begin
                    if (accel_write_enable) begin
                        divisor_reg     <= accel_write_data;
                        step_count      <= '0;
                        part_rem        <= '0;
                        quo_shift       <= dividend_mag;
                        accel_can_write <= 1'b0;
                        state           <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    part_rem   <= next_rem;
                    quo_shift  <= next_quo;
                    step_count <= step_count + 5'd1;
                    if (step_count == 5'(W - 1)) begin
                        quotient_reg   <= final_quo;
                        remainder_reg  <= final_rem;
                        accel_can_read <= 1'b1;
                        state          <= S_QUOTIENT;
                    end
                end
                S_QUOTIENT: begin
                    if (accel_read_enable)
                        state <= S_REMAINDER;
                end
                S_REMAINDER: begin
                    if (accel_read_enable) begin
                        accel_can_read  <= 1'b0;
                        accel_can_write <= 1'b1;
                        state           <= S_DIVIDEND;
                    end
                end
                default: state <= S_DIVIDEND;
            endcase
        end
    end

endmodule
